// File: rtl/matmul_pkg.sv
// Shared encodings for the matmul command path: opcodes, array write selects,
// sequencer states and the step-count helper.
package matmul_pkg;

   typedef enum logic [2:0] {
      MM_ILL0   = 3'b000,
      MM_WRA    = 3'b001,
      MM_WRB    = 3'b010,
      MM_WRC    = 3'b011,
      MM_MATMUL = 3'b100,
      MM_READC  = 3'b101,
      MM_STEP   = 3'b110,
      MM_ILL7   = 3'b111
   } mm_op_e;

   // Low two opcode bits of a write command map directly onto this select.
   typedef enum logic [1:0] {
      MM_SEL_NONE = 2'b00,
      MM_SEL_A    = 2'b01,
      MM_SEL_B    = 2'b10,
      MM_SEL_C    = 2'b11
   } mm_wr_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_RD1,
      ST_RD2
   } mm_state_e;

   // A full DIM x DIM systolic pass needs 3*DIM-2 steps to fill and drain.
   function automatic int mm_steps(input int dim);
      return 3 * dim - 2;
   endfunction

endpackage

// File: rtl/matmul_step_counter.sv
// Up-counter with synchronous load-to-zero, enable and a terminal flag;
// saturates at LAST instead of wrapping.
module matmul_step_counter #(
   parameter int LAST = 21,
   parameter int W    = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         last
);

   always_ff @(posedge clk) begin
      if (rst || load) begin
         count <= '0;
      end else if (en && (count != W'(LAST))) begin
         count <= count + 1'b1;
      end
   end

   assign last = (count == W'(LAST));

endmodule

// File: rtl/matmul_sequencer.sv
// Turns decoded matmul commands into systolic-array write/step/read strobes;
// a matmul runs as a STEPS-cycle step burst with issue back-pressured.
module matmul_sequencer
   import matmul_pkg::*;
#(
   parameter int DIM    = 8,
   parameter int ELEM_W = 32,
   parameter int VLEN   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [2:0]               cmd_op,
   input  logic [$clog2(DIM)-1:0]   cmd_row,
   input  logic                     cmd_high_low,
   input  logic [VLEN*ELEM_W-1:0]   cmd_vec_lo,
   input  logic [VLEN*ELEM_W-1:0]   cmd_vec_hi,
   output logic                     sa_wr_en,
   output logic [1:0]               sa_wr_sel,
   output logic [$clog2(DIM)-1:0]   sa_wr_row,
   output logic [DIM*ELEM_W-1:0]    sa_wr_data,
   output logic                     sa_step,
   output logic [$clog2(DIM)-1:0]   sa_rd_row,
   input  logic [DIM*ELEM_W-1:0]    sa_rd_data,
   output logic                     rd_valid,
   output logic [VLEN*ELEM_W-1:0]   rd_data,
   output logic                     busy,
   output logic                     done,
   output logic                     illegal
);

   localparam int STEPS = mm_steps(DIM);
   localparam int CNT_W = $clog2(STEPS);

   mm_state_e        state_reg;
   mm_op_e           op;
   logic             half_reg;
   logic             accept_matmul;
   logic [CNT_W-1:0] cnt;
   logic             cnt_last;
   logic             cnt_pen;

   assign op            = mm_op_e'(cmd_op);
   assign accept_matmul = (state_reg == ST_IDLE) && cmd_valid && (op == MM_MATMUL);
   assign cnt_pen       = (cnt == CNT_W'(STEPS - 2));

   matmul_step_counter #(
      .LAST (STEPS - 1),
      .W    (CNT_W)
   ) u_step_counter (
      .clk   (clk),
      .rst   (rst),
      .load  (accept_matmul),
      .en    (state_reg == ST_RUN),
      .count (cnt),
      .last  (cnt_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
         sa_wr_en   <= 1'b0;
         sa_wr_sel  <= MM_SEL_NONE;
         sa_wr_row  <= '0;
         sa_wr_data <= '0;
         sa_step    <= 1'b0;
         sa_rd_row  <= '0;
         half_reg   <= 1'b0;
         rd_valid   <= 1'b0;
         done       <= 1'b0;
         illegal    <= 1'b0;
      end else begin
         sa_wr_en <= 1'b0;
         sa_step  <= 1'b0;
         rd_valid <= 1'b0;
         done     <= 1'b0;
         illegal  <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (cmd_valid) begin
                  case (op)
                     MM_WRA, MM_WRB, MM_WRC: begin
                        sa_wr_en   <= 1'b1;
                        sa_wr_sel  <= cmd_op[1:0];
                        sa_wr_row  <= cmd_row;
                        sa_wr_data <= {cmd_vec_hi, cmd_vec_lo};
                     end
                     MM_MATMUL: begin
                        state_reg <= ST_RUN;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        sa_step   <= 1'b1;
                     end
                     MM_READC: begin
                        state_reg <= ST_RD1;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        sa_rd_row <= cmd_row;
                        half_reg  <= cmd_high_low;
                     end
                     MM_STEP: sa_step <= 1'b1;
                     default: illegal <= 1'b1;
                  endcase
               end
            end
            ST_RUN: begin
               // done is raised one cycle early so it lines up with the last step.
               if (cnt_last) begin
                  state_reg <= ST_IDLE;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  sa_step <= 1'b1;
                  done    <= cnt_pen;
               end
            end
            ST_RD1: begin
               state_reg <= ST_RD2;
               rd_valid  <= 1'b1;
            end
            default: begin
               state_reg <= ST_IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // The array's C row only appears during RD2, so the selected half is
   // steered straight through under the registered half select and rd_valid.
   for (genvar gi = 0; gi < VLEN; gi++) begin : g_lane
      logic [ELEM_W-1:0] lo_elem;
      logic [ELEM_W-1:0] hi_elem;
      assign lo_elem = sa_rd_data[gi*ELEM_W +: ELEM_W];
      assign hi_elem = sa_rd_data[(VLEN+gi)*ELEM_W +: ELEM_W];
      assign rd_data[gi*ELEM_W +: ELEM_W] = rd_valid ? (half_reg ? hi_elem : lo_elem) : '0;
   end

endmodule
